vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor of the fixed-mode VGA interval generator.
- Produces hsync, vsync, data-enable, pixel coordinates, line/frame start strobes and a per-frame buffer-select toggle.
- Adds a pixel clock-enable and configurable sync polarity.
- Timing is programmable at run time; new values are shadowed and applied only at a frame boundary.
- Sits between the pixel-clock domain and the framebuffer scan-out/DAC logic.

Parameters:
- CW, 12, width of counters, coordinates and config fields.
- H_ACTIVE, 640, reset horizontal active pixels.
- H_SYNC_START, 656, reset hc at which hsync asserts.
- H_SYNC_END, 752, reset hc at which hsync deasserts.
- H_TOTAL, 800, reset pixels per line.
- V_ACTIVE, 480, reset active lines.
- V_SYNC_START, 490, reset vc at which vsync asserts.
- V_SYNC_END, 492, reset vc at which vsync deasserts.
- V_TOTAL, 525, reset lines per frame.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- pix_ce  in  1  pixel enable; all timing state advances only when high
- cfg_we  in  1  one-cycle write strobe for the cfg_* fields
- cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total  in  CW each  horizontal config
- cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total  in  CW each  vertical config
- cfg_pending  out  1  valid config written, not yet applied
- cfg_err  out  1  one-cycle pulse: rejected write
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  active-video data enable
- x  out  CW  current hc
- y  out  CW  current vc
- line_start  out  1  high during the ce-interval where hc==0
- frame_start  out  1  high during the ce-interval where hc==0 and vc==0
- select  out  1  buffer select, toggles at each frame start

Behaviour:
- Reset is asynchronous, active-low, clock aclk.
- On reset:
  - active timing = parameter defaults; shadow cleared; cfg_pending=0, cfg_err=0.
  - hc=H_TOTAL-1, vc=V_TOTAL-1, so the first pix_ce produces (0,0).
  - de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, x=0, y=0, select=0.
- All outputs are registered. They update on the aclk edge where pix_ce=1 and reflect the new counter values after that edge (zero added latency vs counters). With pix_ce=0 every output holds, including strobes, so strobes span exactly one ce-interval.
- Counter advance per ce: if hc==h_total-1, then hc=0 and vc advances; otherwise hc+1. vc wraps from v_total-1 to 0.
- Decode, all comparisons unsigned CW-bit:
  - de = (hc<h_active) & (vc<v_active).
  - hsync active when h_sync_start<=hc<h_sync_end; vsync active when v_sync_start<=vc<v_sync_end. vsync is evaluated per line, not per pixel.
  - x=hc, y=vc at all times, including blanking.
  - frame_start on the wrap into (0,0). select toggles on that same edge.
- Config write (cfg_we=1, any pix_ce):
  - Legal when 1<=active<sync_start<sync_end<=total, checked independently for h and v; both must pass.
  - Legal write: fields go to shadow, cfg_pending=1. A later write before apply overwrites the shadow.
  - Illegal write: shadow and pending unchanged, cfg_err=1 for one aclk.
- Apply: on the ce edge where the counters wrap into (0,0), if cfg_pending then active:=shadow and cfg_pending:=0. The new timing governs the decode of (0,0) on that same edge.
- If cfg_we and apply coincide, the apply uses the old shadow and the new write becomes pending.
- Mid-frame writes never alter the current frame.
- Reset mid-frame discards the shadow and returns to the defaults.

Test Plan:
- Defaults, pix_ce=1 constant, run 2 frames:
  - hsync low for hc 656..751, 96 clocks per line; line period 800.
  - vsync low for lines 490..491; frame period 420000 clocks.
  - de high 640 clocks/line for lines 0..479; select toggles twice.
- pix_ce high 1 in 3 clocks: all periods ×3 in aclk; outputs and strobes stable for 3 clocks each.
- Write h=(4,5,6,8), v=(2,3,4,5) mid-frame:
  - cfg_pending=1; timing unchanged until next (0,0).
  - Then line=8 pixels, frame=40 pixels; hsync active only at hc=5; vsync active only at vc=3; cfg_pending=0.
- Illegal write h_sync_start=h_active, e.g. (4,4,6,8) → cfg_err one-cycle pulse; pending unchanged; timing unchanged.
- cfg_we on the apply edge with pending: old shadow applied; new values pending; applied one frame later.
- HS_POL=1, VS_POL=1 build: syncs idle low after reset and pulse high at the same positions; assert aresetn mid-frame → outputs return to reset values asynchronously; first ce after release gives frame_start=1, x=0, y=0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - config bus and video timing outputs of vga_timing_gen
// master: config writer / scan-out side; slave: the timing generator.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          cfg_we;
  logic [CW-1:0] cfg_h_active;
  logic [CW-1:0] cfg_h_sync_start;
  logic [CW-1:0] cfg_h_sync_end;
  logic [CW-1:0] cfg_h_total;
  logic [CW-1:0] cfg_v_active;
  logic [CW-1:0] cfg_v_sync_start;
  logic [CW-1:0] cfg_v_sync_end;
  logic [CW-1:0] cfg_v_total;
  logic          cfg_pending;
  logic          cfg_err;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          select;

  modport master (
    output cfg_we, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
           cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
    input  cfg_pending, cfg_err, hsync, vsync, de, x, y,
           line_start, frame_start, select
  );

  modport slave (
    input  cfg_we, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
           cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
    output cfg_pending, cfg_err, hsync, vsync, de, x, y,
           line_start, frame_start, select
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - programmable VGA timing generator with frame-boundary config apply
// Counters advance on pix_ce; all outputs are registered from the next counter values,
// so they change together with the counters and hold while pix_ce is low.
module vga_timing_gen #(
  parameter int CW           = 12,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         pix_ce,
  vga_timing_gen_if.slave bus
);

  typedef struct packed {
    logic [CW-1:0] ha;
    logic [CW-1:0] hss;
    logic [CW-1:0] hse;
    logic [CW-1:0] ht;
    logic [CW-1:0] va;
    logic [CW-1:0] vss;
    logic [CW-1:0] vse;
    logic [CW-1:0] vt;
  } timing_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam timing_t DEFAULTS = {CW'(H_ACTIVE), CW'(H_SYNC_START), CW'(H_SYNC_END), CW'(H_TOTAL),
                                  CW'(V_ACTIVE), CW'(V_SYNC_START), CW'(V_SYNC_END), CW'(V_TOTAL)};
  localparam logic [CW-1:0] HC_RESET = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VC_RESET = CW'(V_TOTAL - 1);

  timing_t       act;
  timing_t       shd;
  timing_t       wr;
  timing_t       eff;
  logic          pending;
  logic          err;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] hc_nx;
  logic [CW-1:0] vc_nx;
  logic          h_wrap;
  logic          f_wrap;
  logic          apply;
  logic          wr_ok;
  logic          de_q;
  logic          hsync_q;
  logic          vsync_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          line_start_q;
  logic          frame_start_q;
  logic          select_q;

  assign wr = {bus.cfg_h_active, bus.cfg_h_sync_start, bus.cfg_h_sync_end, bus.cfg_h_total,
               bus.cfg_v_active, bus.cfg_v_sync_start, bus.cfg_v_sync_end, bus.cfg_v_total};

  // A write is accepted only if both axes satisfy 1 <= active < sync_start < sync_end <= total.
  always_comb begin
    wr_ok = (wr.ha != '0) && (wr.ha < wr.hss) && (wr.hss < wr.hse) && (wr.hse <= wr.ht) &&
            (wr.va != '0) && (wr.va < wr.vss) && (wr.vss < wr.vse) && (wr.vse <= wr.vt);
  end

  // Next counter position; the wrap into (0,0) is also where a pending config takes over,
  // and the decode of that first pixel already uses the new timing.
  always_comb begin
    h_wrap = (hc == act.ht - ONE);
    f_wrap = h_wrap && (vc == act.vt - ONE);
    hc_nx  = h_wrap ? '0 : hc + ONE;
    vc_nx  = h_wrap ? (f_wrap ? '0 : vc + ONE) : vc;
    apply  = f_wrap && pending;
    eff    = apply ? shd : act;
  end

  // Timing registers: counters, active/shadow config, pending flag and reject pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      act     <= DEFAULTS;
      shd     <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
      hc      <= HC_RESET;
      vc      <= VC_RESET;
    end else begin
      err <= bus.cfg_we && !wr_ok;
      if (pix_ce) begin
        hc <= hc_nx;
        vc <= vc_nx;
      end
      if (pix_ce && apply) begin
        act <= shd;
      end
      // A write landing on the apply edge becomes the next pending config.
      if (bus.cfg_we && wr_ok) begin
        shd     <= wr;
        pending <= 1'b1;
      end else if (pix_ce && apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered video outputs decoded from the next counter values under the effective timing.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      select_q      <= 1'b0;
    end else if (pix_ce) begin
      de_q          <= (hc_nx < eff.ha) && (vc_nx < eff.va);
      hsync_q       <= ((hc_nx >= eff.hss) && (hc_nx < eff.hse)) ? HS_POL : ~HS_POL;
      vsync_q       <= ((vc_nx >= eff.vss) && (vc_nx < eff.vse)) ? VS_POL : ~VS_POL;
      x_q           <= hc_nx;
      y_q           <= vc_nx;
      line_start_q  <= (hc_nx == '0);
      frame_start_q <= f_wrap;
      if (f_wrap) begin
        select_q <= ~select_q;
      end
    end
  end

  assign bus.cfg_pending = pending;
  assign bus.cfg_err     = err;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.select      = select_q;

endmodule
